// File: rtl/forwarding_unit_p_if.sv
// forwarding_unit_p_if: EX-stage operand/forwarding bus; master = pipeline side, slave = forwarding unit
//   inputs to the unit : ex_* instruction fields, stage_result (slice k = stage k), flush, hold
//   outputs of the unit: op_a, op_b, fwd_src_a, fwd_src_b, stall, stall_cnt
interface forwarding_unit_p_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
);
    logic                     ex_valid;
    logic [REG_AW-1:0]        ex_rs;
    logic [REG_AW-1:0]        ex_rt;
    logic                     ex_use_rs;
    logic                     ex_use_rt;
    logic                     ex_imm_sel;
    logic [DATA_W-1:0]        ex_a;
    logic [DATA_W-1:0]        ex_b;
    logic [DATA_W-1:0]        ex_imm;
    logic                     ex_wr_en;
    logic [REG_AW-1:0]        ex_wr_reg;
    logic                     ex_is_load;
    logic [STAGES*DATA_W-1:0] stage_result;
    logic                     flush;
    logic                     hold;
    logic [DATA_W-1:0]        op_a;
    logic [DATA_W-1:0]        op_b;
    logic [2:0]               fwd_src_a;
    logic [2:0]               fwd_src_b;
    logic                     stall;
    logic [CNT_W-1:0]         stall_cnt;
    modport master (
        output ex_valid, ex_rs, ex_rt, ex_use_rs, ex_use_rt, ex_imm_sel, ex_a, ex_b, ex_imm,
               ex_wr_en, ex_wr_reg, ex_is_load, stage_result, flush, hold,
        input  op_a, op_b, fwd_src_a, fwd_src_b, stall, stall_cnt
    );
    modport slave (
        input  ex_valid, ex_rs, ex_rt, ex_use_rs, ex_use_rt, ex_imm_sel, ex_a, ex_b, ex_imm,
               ex_wr_en, ex_wr_reg, ex_is_load, stage_result, flush, hold,
        output op_a, op_b, fwd_src_a, fwd_src_b, stall, stall_cnt
    );
endinterface

// File: rtl/forwarding_unit_p.sv
// forwarding_unit_p: EX operand forwarding + load-use stall detection with saturating stall counter
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears in-flight tags and stall_cnt)
//   bus   : forwarding_unit_p_if.slave (EX fields and stage results in, operands/stall out)
module forwarding_unit_p #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int STAGES   = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    forwarding_unit_p_if.slave   bus
);
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ld;
    logic [REG_AW-1:0] dst [STAGES];
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] da, db;
    logic [2:0]        sa, sb;
    logic              pa, pb, stall;
    // scanning oldest to youngest lets the youngest match overwrite older ones
    always_comb begin
        da = bus.ex_a;
        db = bus.ex_b;
        sa = '0;
        sb = '0;
        pa = 1'b0;
        pb = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (vld[k] && dst[k] == bus.ex_rs && bus.ex_rs != '0 && bus.ex_use_rs && bus.ex_valid) begin
                da = bus.stage_result[k*DATA_W +: DATA_W];
                sa = 3'(k + 1);
                pa = ld[k] && (k < LOAD_LAT);
            end
            if (vld[k] && dst[k] == bus.ex_rt && bus.ex_rt != '0 && bus.ex_use_rt && bus.ex_valid) begin
                db = bus.stage_result[k*DATA_W +: DATA_W];
                sb = 3'(k + 1);
                pb = ld[k] && (k < LOAD_LAT);
            end
        end
    end
    assign stall         = (pa | pb) & ~bus.flush;
    assign bus.stall     = stall;
    assign bus.op_a      = da;
    assign bus.op_b      = bus.ex_imm_sel ? bus.ex_imm : db;
    assign bus.fwd_src_a = sa;
    assign bus.fwd_src_b = bus.ex_imm_sel ? 3'd0 : sb;
    assign bus.stall_cnt = cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            ld  <= '0;
            cnt <= '0;
            for (int k = 0; k < STAGES; k++) dst[k] <= '0;
        end else if (!bus.hold) begin
            // flushed or stalled instruction enters the pipe as a bubble
            vld[0] <= ~(bus.flush | stall) & bus.ex_valid & bus.ex_wr_en & (bus.ex_wr_reg != '0);
            ld[0]  <= bus.ex_is_load;
            dst[0] <= bus.ex_wr_reg;
            for (int k = 1; k < STAGES; k++) begin
                vld[k] <= vld[k-1];
                ld[k]  <= ld[k-1];
                dst[k] <= dst[k-1];
            end
            if (stall && cnt != '1) cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_forwarding_unit_p.sv
// tb_forwarding_unit_p: directed table, randomized model-checked run and control corner cases
module tb_forwarding_unit_p;
    localparam int ST = 2;
    localparam int LL = 1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    forwarding_unit_p_if #(.DATA_W(32), .REG_AW(5), .STAGES(ST), .CNT_W(16)) bus ();
    forwarding_unit_p_if #(.DATA_W(32), .REG_AW(5), .STAGES(ST), .CNT_W(2))  bus2 ();
    forwarding_unit_p #(.DATA_W(32), .REG_AW(5), .STAGES(ST), .LOAD_LAT(LL), .CNT_W(16))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    forwarding_unit_p #(.DATA_W(32), .REG_AW(5), .STAGES(ST), .LOAD_LAT(LL), .CNT_W(2))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    assign bus2.ex_valid     = bus.ex_valid;
    assign bus2.ex_rs        = bus.ex_rs;
    assign bus2.ex_rt        = bus.ex_rt;
    assign bus2.ex_use_rs    = bus.ex_use_rs;
    assign bus2.ex_use_rt    = bus.ex_use_rt;
    assign bus2.ex_imm_sel   = bus.ex_imm_sel;
    assign bus2.ex_a         = bus.ex_a;
    assign bus2.ex_b         = bus.ex_b;
    assign bus2.ex_imm       = bus.ex_imm;
    assign bus2.ex_wr_en     = bus.ex_wr_en;
    assign bus2.ex_wr_reg    = bus.ex_wr_reg;
    assign bus2.ex_is_load   = bus.ex_is_load;
    assign bus2.stage_result = bus.stage_result;
    assign bus2.flush        = bus.flush;
    assign bus2.hold         = bus.hold;

    typedef struct {bit v; int d; bit l;} ent_t;
    ent_t pipe[$];
    int mcnt, mcnt2;

    typedef struct {
        int vld, rs, rt, urs, urt, imm, wen, wr, ld;
        logic [31:0] s0, s1;
        int xs;
        logic [31:0] xa, xb;
        int sa, sb;
    } vec_t;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        for (int k = 0; k < ST; k++) pipe.push_back('{1'b0, 0, 1'b0});
        mcnt = 0;
        mcnt2 = 0;
    endtask

    function automatic int youngest(int r, bit u);
        if (!u || !bus.ex_valid || r == 0) return -1;
        foreach (pipe[k]) if (pipe[k].v && pipe[k].d == r) return k;
        return -1;
    endfunction

    task automatic eval(output logic [31:0] a, output logic [31:0] b,
                        output logic [2:0] sa, output logic [2:0] sb, output logic st);
        int ka, kb;
        ka = youngest(int'(bus.ex_rs), bus.ex_use_rs);
        kb = youngest(int'(bus.ex_rt), bus.ex_use_rt);
        a  = ka < 0 ? bus.ex_a : bus.stage_result[ka*32 +: 32];
        sa = 3'(ka + 1);
        b  = bus.ex_imm_sel ? bus.ex_imm : kb < 0 ? bus.ex_b : bus.stage_result[kb*32 +: 32];
        sb = bus.ex_imm_sel ? 3'd0 : 3'(kb + 1);
        st = ((ka >= 0 && pipe[ka].l && ka < LL) || (kb >= 0 && pipe[kb].l && kb < LL)) && !bus.flush;
    endtask

    // compare against the model, then advance the model across one rising edge
    task automatic cyc(input bit c);
        logic [31:0] a, b;
        logic [2:0] sa, sb;
        logic st;
        ent_t e;
        #1;
        eval(a, b, sa, sb, st);
        if (c) begin
            chk("stall", 32'(bus.stall), 32'(st));
            if (!st) begin
                chk("op_a", bus.op_a, a);
                chk("op_b", bus.op_b, b);
                chk("fwd_src_a", 32'(bus.fwd_src_a), 32'(sa));
                chk("fwd_src_b", 32'(bus.fwd_src_b), 32'(sb));
            end
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(mcnt));
            chk("stall_cnt_sat", 32'(bus2.stall_cnt), 32'(mcnt2));
        end
        @(posedge clk);
        if (!bus.hold) begin
            e.v = !(bus.flush || st) && bus.ex_valid && bus.ex_wr_en && bus.ex_wr_reg != 0;
            e.d = int'(bus.ex_wr_reg);
            e.l = bus.ex_is_load;
            pipe.push_front(e);
            void'(pipe.pop_back());
            if (st) begin
                mcnt  = mcnt  < 65535 ? mcnt + 1  : mcnt;
                mcnt2 = mcnt2 < 3     ? mcnt2 + 1 : mcnt2;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(int vld, int rs, int rt, int urs, int urt, int imm,
                         int wen, int wr, int ld, int fl, int hd);
        bus.ex_valid   = 1'(vld);
        bus.ex_rs      = 5'(rs);
        bus.ex_rt      = 5'(rt);
        bus.ex_use_rs  = 1'(urs);
        bus.ex_use_rt  = 1'(urt);
        bus.ex_imm_sel = 1'(imm);
        bus.ex_wr_en   = 1'(wen);
        bus.ex_wr_reg  = 5'(wr);
        bus.ex_is_load = 1'(ld);
        bus.flush      = 1'(fl);
        bus.hold       = 1'(hd);
    endtask

    task automatic nops();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (ST) cyc(1);
    endtask

    initial begin
        vec_t tbl[9];
        logic [31:0] c0;
        tbl[0] = '{1, 1, 2, 1, 1, 0, 1, 3, 0, 32'h11, 32'h99, 0, 32'hA,  32'hB,  0, 0};
        tbl[1] = '{1, 3, 2, 1, 1, 0, 1, 4, 0, 32'h11, 32'h99, 0, 32'h11, 32'hB,  1, 0};
        tbl[2] = '{1, 3, 2, 1, 1, 0, 1, 4, 0, 32'h11, 32'h77, 0, 32'h77, 32'hB,  2, 0};
        tbl[3] = '{1, 3, 4, 1, 1, 0, 0, 0, 0, 32'h33, 32'h22, 0, 32'hA,  32'h33, 0, 1};
        tbl[4] = '{1, 0, 4, 0, 0, 0, 1, 5, 1, 32'h33, 32'h22, 0, 32'hA,  32'hB,  0, 0};
        tbl[5] = '{1, 5, 0, 1, 0, 0, 1, 6, 0, 32'h0,  32'h55, 1, 32'h0,  32'h0,  0, 0};
        tbl[6] = '{1, 5, 0, 1, 0, 0, 1, 6, 0, 32'h0,  32'h55, 0, 32'h55, 32'hB,  2, 0};
        tbl[7] = '{1, 0, 6, 1, 1, 1, 1, 0, 0, 32'h66, 32'h0,  0, 32'hA,  32'hC,  0, 0};
        tbl[8] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0,  32'h0,  0, 32'hA,  32'hB,  0, 0};
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.ex_a = 32'hA;
        bus.ex_b = 32'hB;
        bus.ex_imm = 32'hC;
        bus.stage_result = '0;
        model_reset();
        #2;
        chk("rst_op_a", bus.op_a, 32'hA);
        chk("rst_op_b", bus.op_b, 32'hB);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_cnt", 32'(bus.stall_cnt), 0);
        chk("rst_src_a", 32'(bus.fwd_src_a), 0);
        chk("rst_src_b", 32'(bus.fwd_src_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].imm,
                  tbl[i].wen, tbl[i].wr, tbl[i].ld, 0, 0);
            bus.stage_result = {tbl[i].s1, tbl[i].s0};
            #1;
            chk($sformatf("tbl%0d_stall", i), 32'(bus.stall), 32'(tbl[i].xs));
            if (tbl[i].xs == 0) begin
                chk($sformatf("tbl%0d_op_a", i), bus.op_a, tbl[i].xa);
                chk($sformatf("tbl%0d_op_b", i), bus.op_b, tbl[i].xb);
                chk($sformatf("tbl%0d_src_a", i), 32'(bus.fwd_src_a), 32'(tbl[i].sa));
                chk($sformatf("tbl%0d_src_b", i), 32'(bus.fwd_src_b), 32'(tbl[i].sb));
            end
            cyc(1);
        end
        chk("tbl_stall_cnt", 32'(bus.stall_cnt), 1);
        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), int'($urandom_range(0, 4) == 0),
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                  int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 9) == 0));
            bus.ex_a = $urandom;
            bus.ex_b = $urandom;
            bus.ex_imm = $urandom;
            bus.stage_result = {$urandom, $urandom};
            cyc(1);
        end
        chk("sat_cnt2", 32'(bus2.stall_cnt), 32'(mcnt2));
        bus.stage_result = {32'h55, 32'h44};
        nops();
        drive(1, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        cyc(1);
        c0 = 32'(bus.stall_cnt);
        drive(1, 5, 0, 1, 0, 0, 1, 6, 0, 0, 1);
        repeat (2) begin
            #1;
            chk("hold_stall", 32'(bus.stall), 1);
            chk("hold_cnt", 32'(bus.stall_cnt), c0);
            cyc(1);
        end
        bus.hold = 1'b0;
        cyc(1);
        chk("hold_cnt_inc", 32'(bus.stall_cnt), c0 + 1);
        #1;
        chk("after_stall_op_a", bus.op_a, 32'h55);
        chk("after_stall_src_a", 32'(bus.fwd_src_a), 2);
        cyc(1);
        nops();
        drive(1, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        cyc(1);
        drive(1, 5, 0, 1, 0, 0, 1, 7, 0, 1, 0);
        #1;
        chk("flush_stall", 32'(bus.stall), 0);
        cyc(1);
        drive(1, 7, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("flush_bubble_op_a", bus.op_a, bus.ex_a);
        chk("flush_bubble_src_a", 32'(bus.fwd_src_a), 0);
        chk("flush_old_op_b", bus.op_b, 32'h55);
        cyc(1);
        nops();
        drive(1, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        cyc(1);
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_stall", 32'(bus.stall), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(bus.stall), 0);
        chk("mid_rst_cnt", 32'(bus.stall_cnt), 0);
        chk("mid_rst_op_a", bus.op_a, bus.ex_a);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
